// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk_in
// cycles, strobing each new result and flagging loss of signal via timeout.
module period_meter #(
  parameter int                 CNT_W   = 26,
  parameter logic [CNT_W-1:0]   TIMEOUT = 26'd60000000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             timeout,
  output logic             locked
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_s1, r_s2, r_s3;
  logic             w_rise, w_fall;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_hcap, w_hcap_nxt;
  logic [CNT_W-1:0] r_period, w_period_nxt;
  logic [CNT_W-1:0] r_high, w_high_nxt;
  logic             r_pv, w_pv_nxt;
  logic             r_to, w_to_nxt;
  logic             r_locked, w_locked_nxt;

  // Two flops settle metastability; the third holds the previous level for edge detection.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;

  // NOTE: every signal is defaulted before the case so no path can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_hcap_nxt   = r_hcap;
    w_period_nxt = r_period;
    w_high_nxt   = r_high;
    w_pv_nxt     = 1'b0;
    w_to_nxt     = 1'b0;
    w_locked_nxt = r_locked;

    case (r_state)
      IDLE: begin
        w_cnt_nxt    = '0;
        w_locked_nxt = 1'b0;
        if (w_rise && en) begin
          w_cnt_nxt   = CNT_ONE;
          w_state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (!en) begin
          w_state_nxt  = IDLE;
          w_cnt_nxt    = '0;
          w_locked_nxt = 1'b0;
        end else if (w_rise) begin
          // A rise landing exactly on the timeout count still counts as a valid period.
          w_period_nxt = r_cnt;
          w_high_nxt   = r_hcap;
          w_pv_nxt     = 1'b1;
          w_locked_nxt = 1'b1;
          w_cnt_nxt    = CNT_ONE;
        end else if (r_cnt == TIMEOUT) begin
          w_to_nxt     = 1'b1;
          w_locked_nxt = 1'b0;
          w_cnt_nxt    = '0;
          w_state_nxt  = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
          if (w_fall) w_hcap_nxt = r_cnt;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_hcap   <= '0;
      r_period <= '0;
      r_high   <= '0;
      r_pv     <= 1'b0;
      r_to     <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_hcap   <= w_hcap_nxt;
      r_period <= w_period_nxt;
      r_high   <= w_high_nxt;
      r_pv     <= w_pv_nxt;
      r_to     <= w_to_nxt;
      r_locked <= w_locked_nxt;
    end
  end

  assign period       = r_period;
  assign high_time    = r_high;
  assign period_valid = r_pv;
  assign timeout      = r_to;
  assign locked       = r_locked;

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: table-driven square waves, hand-written
// corner sequences and random bursts, all checked against an event-time model.
module tb_period_meter;

  localparam int              CNT_W  = 8;
  localparam logic [CNT_W-1:0] TO_CYC = 8'd20;

  logic             clk_in = 1'b0;
  logic             rst;
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             timeout;
  logic             locked;

  period_meter #(.CNT_W(CNT_W), .TIMEOUT(TO_CYC)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .en          (en),
    .sig_in      (sig_in),
    .period      (period),
    .high_time   (high_time),
    .period_valid(period_valid),
    .timeout     (timeout),
    .locked      (locked)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  // Event-level model: tracks the tick of the last detected rise and derives
  // intervals by subtraction. Input edges are seen two ticks late (synchronizer).
  int  t = 0;
  bit  m_meas;
  int  m_t0, m_hcap, m_period, m_high;
  bit  m_pv, m_to, m_locked;
  bit  hist [3];

  int  n_pv, n_to, to_tick, rise_tick;
  int  last_p, last_h;
  bit  saw_lock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @tick %0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    m_meas = 0; m_t0 = 0; m_hcap = 0; m_period = 0; m_high = 0;
    m_pv = 0; m_to = 0; m_locked = 0;
    for (int i = 0; i < 3; i++) hist[i] = 1'b0;
  endtask

  task automatic model_step(input bit e, input bit s);
    bit rise, fall;
    rise = hist[1] & ~hist[2];
    fall = ~hist[1] & hist[2];
    m_pv = 0;
    m_to = 0;
    if (!m_meas) begin
      if (rise && e) begin m_meas = 1; m_t0 = t; end
    end else if (!e) begin
      m_meas = 0; m_locked = 0;
    end else if (rise) begin
      m_pv = 1; m_period = t - m_t0; m_high = m_hcap; m_locked = 1; m_t0 = t;
    end else if (t - m_t0 == int'(TO_CYC)) begin
      m_to = 1; m_locked = 0; m_meas = 0;
    end else if (fall) begin
      m_hcap = t - m_t0;
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = s;
  endtask

  task automatic tick(input bit e, input bit s);
    t++;
    en = e;
    sig_in = s;
    @(posedge clk_in);
    #1;
    model_step(e, s);
    check("cycle", {period, high_time, period_valid, timeout, locked},
          {m_period[CNT_W-1:0], m_high[CNT_W-1:0], m_pv, m_to, m_locked});
    if (period_valid) begin n_pv++; last_p = period; last_h = high_time; end
    if (timeout) begin n_to++; to_tick = t; end
    if (locked) saw_lock = 1;
  endtask

  task automatic wave(input int hi, input int lo, input int reps, input bit e);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) tick(e, 1'b1);
      for (int i = 0; i < lo; i++) tick(e, 1'b0);
    end
  endtask

  // Pulse reset between clock edges and check that outputs clear without a clock.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 check("rst_async_outs", {period, high_time, period_valid, timeout, locked}, 32'h0);
    #2 rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    int hi;
    int lo;
    int reps;
    int exp_p;
    int exp_h;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p_before, h_before;

    vecs[0] = '{5, 5, 4, 10, 5};
    vecs[1] = '{3, 7, 4, 10, 3};
    vecs[2] = '{12, 4, 3, 16, 12};
    vecs[3] = '{1, 1, 4, 2, 1};
    vecs[4] = '{10, 10, 3, 20, 10};
    vecs[5] = '{1, 19, 3, 20, 1};

    rst = 1'b1; en = 1'b0; sig_in = 1'b0;
    model_reset();
    #12;
    check("reset_outs", {period, high_time, period_valid, timeout, locked}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);

    // Table: steady square waves, last strobe must report the pure pattern.
    foreach (vecs[i]) begin
      n_pv = 0;
      wave(vecs[i].hi, vecs[i].lo, vecs[i].reps, 1'b1);
      check("tbl_strobe_seen", 32'(n_pv > 0), 32'd1);
      check("tbl_period", last_p, vecs[i].exp_p);
      check("tbl_high", last_h, vecs[i].exp_h);
      check("tbl_locked", locked, 1);
    end

    // Lost signal: single rise, then held high.
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b0);
    n_pv = 0; n_to = 0; saw_lock = 0;
    tick(1'b1, 1'b1);
    rise_tick = t;
    for (int i = 0; i < 39; i++) tick(1'b1, 1'b1);
    check("to_count", n_to, 1);
    check("to_tick", to_tick, rise_tick + 22);
    check("to_no_strobe", n_pv, 0);
    check("to_never_locked", saw_lock, 0);
    wave(5, 5, 4, 1'b1);
    check("to_recover_period", last_p, 10);
    check("to_recover_high", last_h, 5);
    check("to_recover_locked", locked, 1);

    // Rise spacing exactly at the timeout, then one past it.
    wave(1, 19, 2, 1'b1);
    n_to = 0; n_pv = 0;
    wave(1, 19, 3, 1'b1);
    check("edge20_no_timeout", n_to, 0);
    check("edge20_period", last_p, 20);
    wave(1, 20, 1, 1'b1);
    n_pv = 0; n_to = 0;
    wave(1, 20, 4, 1'b1);
    check("edge21_timeouts", 32'(n_to >= 2), 32'd1);
    check("edge21_no_strobe", n_pv, 0);

    // Reset mid-period: needs two fresh rises afterwards.
    wave(5, 5, 3, 1'b1);
    check("rst_pre_locked", locked, 1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    async_reset();
    n_pv = 0;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    wave(5, 5, 1, 1'b1);
    check("rst_one_rise_no_strobe", n_pv, 0);
    check("rst_one_rise_unlocked", locked, 0);
    wave(5, 5, 1, 1'b1);
    check("rst_two_rises_strobe", n_pv, 1);
    check("rst_two_rises_period", last_p, 10);

    // Enable dropped for three cycles while locked.
    wave(5, 5, 3, 1'b1);
    check("en_pre_locked", locked, 1);
    p_before = period;
    h_before = high_time;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    n_pv = 0;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("en_off_unlocked", locked, 0);
    check("en_off_period_hold", period, p_before);
    check("en_off_high_hold", high_time, h_before);
    check("en_off_no_strobe", n_pv, 0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    wave(5, 5, 1, 1'b1);
    check("en_back_one_rise", n_pv, 0);
    wave(5, 5, 1, 1'b1);
    check("en_back_two_rises", n_pv, 1);

    // Random bursts checked cycle by cycle against the model.
    for (int i = 0; i < 200; i++) begin
      wave($urandom_range(1, 12), $urandom_range(1, 14), 1, $urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
